// File: rtl/alu_op_sequencer.sv
// Control sequencer for one fetch/decode/execute pass of a register-to-register ALU instruction.
// Optional MUL/DIV support (two-cycle LO/HI result write-back) is enabled by defining ALU_SEQ_MULDIV_EN.
module alu_op_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir_data,
  output logic                pc_out,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                mdr_out,
  output logic                mar_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic                inc_pc,
  output logic                read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPC_W-1:0]    alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal_op
);

  localparam int RSEL_W = $clog2(NUM_REGS);
  localparam int LOW_W  = DATA_W - OPC_W - 3 * RSEL_W;

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
`else
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_t;
`endif

  state_t state_reg, state_next;
  logic   t1_wait_reg;

  logic [OPC_W-1:0]    opcode;
  logic [RSEL_W-1:0]   ra, rb, rc;
  logic [NUM_REGS-1:0] ra_hot, rb_hot, rc_hot;
  logic                is_muldiv, legal;

  assign opcode = ir_data[DATA_W-1 -: OPC_W];
  assign ra     = ir_data[DATA_W-OPC_W-1 -: RSEL_W];
  assign rb     = ir_data[DATA_W-OPC_W-RSEL_W-1 -: RSEL_W];
  assign rc     = ir_data[DATA_W-OPC_W-2*RSEL_W-1 -: RSEL_W];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign ra_hot[gi] = (ra == RSEL_W'(gi));
      assign rb_hot[gi] = (rb == RSEL_W'(gi));
      assign rc_hot[gi] = (rc == RSEL_W'(gi));
    end
    if (LOW_W > 0) begin : g_unused
      logic unused_low;
      assign unused_low = ^ir_data[LOW_W-1:0];
    end
  endgenerate

`ifdef ALU_SEQ_MULDIV_EN
  assign is_muldiv = (opcode == OPC_W'(5'b01111)) || (opcode == OPC_W'(5'b10000));
`else
  assign is_muldiv = 1'b0;
`endif
  assign legal = ((opcode >= OPC_W'(5'b00011)) && (opcode <= OPC_W'(5'b01010))) || is_muldiv;

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_reg   <= IDLE;
      t1_wait_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Marks T1 cycles after the first, so pc_in is strobed only once per fetch.
      t1_wait_reg <= (state_reg == T1);
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_out     = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    mdr_out    = 1'b0;
    mar_in     = 1'b0;
    pc_in      = 1'b0;
    mdr_in     = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    inc_pc     = 1'b0;
    read       = 1'b0;
    reg_out    = '0;
    reg_in     = '0;
    alu_op     = '0;
    done       = 1'b0;
    illegal_op = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (start) state_next = T0;
      T0: begin
        pc_out     = 1'b1;
        mar_in     = 1'b1;
        inc_pc     = 1'b1;
        z_in       = 1'b1;
        state_next = T1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = !t1_wait_reg;
        read     = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ready) state_next = T2;
      end
      T2: begin
        mdr_out    = 1'b1;
        ir_in      = 1'b1;
        state_next = T3;
      end
      T3: begin
        if (legal) begin
          reg_out    = rb_hot;
          y_in       = 1'b1;
          state_next = T4;
        end else begin
          illegal_op = 1'b1;
          state_next = IDLE;
        end
      end
      T4: begin
        reg_out    = rc_hot;
        z_in       = 1'b1;
        alu_op     = opcode;
        state_next = T5;
      end
      T5: begin
        zlow_out = 1'b1;
        if (is_muldiv) begin
          lo_in      = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
          state_next = T6;
`else
          state_next = IDLE;
`endif
        end else begin
          reg_in     = ra_hot;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      T6: begin
        zhigh_out  = 1'b1;
        hi_in      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: end-of-instruction pulses are checked against queued expectations.
module tb_alu_op_sequencer;
  logic        Clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir_data;
  logic        pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
  logic        y_in, z_in, lo_in, hi_in, inc_pc, read, busy, done, illegal_op;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir_data(ir_data),
    .pc_out(pc_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out), .mdr_out(mdr_out),
    .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .lo_in(lo_in), .hi_in(hi_in), .inc_pc(inc_pc), .read(read), .reg_out(reg_out),
    .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done), .illegal_op(illegal_op)
  );

  always #5 Clock = ~Clock;

  localparam logic [16:0] M_PCOUT = 17'b1 << 16, M_ZLOW = 17'b1 << 15, M_ZHIGH = 17'b1 << 14,
                          M_MDROUT = 17'b1 << 13, M_MARIN = 17'b1 << 12, M_PCIN = 17'b1 << 11,
                          M_MDRIN = 17'b1 << 10, M_IRIN = 17'b1 << 9, M_YIN = 17'b1 << 8,
                          M_ZIN = 17'b1 << 7, M_LOIN = 17'b1 << 6, M_HIIN = 17'b1 << 5,
                          M_INCPC = 17'b1 << 4, M_READ = 17'b1 << 3, M_BUSY = 17'b1 << 2,
                          M_DONE = 17'b1 << 1, M_ILL = 17'b1;

  logic [16:0] ctrl;
  assign ctrl = {pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in,
                 z_in, lo_in, hi_in, inc_pc, read, busy, done, illegal_op};

  typedef struct {
    logic [16:0] ctrl;
    logic [15:0] regin;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] opc);
    if (opc >= 5'd3 && opc <= 5'd10) return 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
    if (opc == 5'd15 || opc == 5'd16) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [16:0] trace_exp(input int c);
    case (c)
      0: return M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
      1: return M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_BUSY;
      2: return M_MDROUT | M_IRIN | M_BUSY;
      3: return M_YIN | M_BUSY;
      4: return M_ZIN | M_BUSY;
      default: return M_ZLOW | M_BUSY | M_DONE;
    endcase
  endfunction

  // Scoreboard consumer: every done / illegal_op pulse retires exactly one queued instruction.
  always @(negedge Clock) begin
    if (!clear && (done || illegal_op)) begin
      if (sb.size() == 0) begin
        check("unexpected_end", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("end of instr at cycle %0d: ctrl=%05h reg_in=%04h", cyc, ctrl, reg_in);
        check("end_ctrl", 32'(ctrl), 32'(e.ctrl));
        check("end_reg_in", 32'(reg_in), 32'(e.regin));
        check("end_reg_out", 32'(reg_out), 32'd0);
        check("end_latency", cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic run_instr(input logic [31:0] ir, input int w, input bit trace, input bit start_mid);
    exp_t e;
    int c, waits, busy_lat;
    bit seen_t1, md;
    logic [4:0] opc;
    opc = ir[31:27];
    md = (opc == 5'd15 || opc == 5'd16) && is_legal(opc);
    e.regin = '0;
    if (!is_legal(opc)) begin
      e.ctrl = M_BUSY | M_ILL; e.lat = 4 + w; busy_lat = 5 + w;
    end else if (md) begin
      e.ctrl = M_ZHIGH | M_HIIN | M_BUSY | M_DONE; e.lat = 7 + w; busy_lat = 8 + w;
    end else begin
      e.ctrl = M_ZLOW | M_BUSY | M_DONE; e.lat = 6 + w; busy_lat = 7 + w;
      e.regin = 16'h1 << ir[26:23];
    end
    sb.push_back(e);
    ir_data = ir; start = 1'b1; mem_ready = 1'b1; start_cyc = cyc;
    c = 0; waits = 0; seen_t1 = 1'b0;
    @(negedge Clock);
    start = 1'b0;
    while (busy && c < 40) begin
      if (read) begin
        check("t1_mdr_in", 32'(mdr_in), 32'd1);
        check("t1_pc_in", 32'(pc_in), 32'(!seen_t1));
        seen_t1 = 1'b1;
        if (waits < w) begin mem_ready = 1'b0; waits++; end
        else mem_ready = 1'b1;
      end
      if (trace && c < 6) check("trace_ctrl", 32'(ctrl), 32'(trace_exp(c)));
      if (trace && c == 3) check("t3_reg_out", 32'(reg_out), 32'(16'h1 << ir[22:19]));
      if (trace && c == 4) check("t4_reg_out", 32'(reg_out), 32'(16'h1 << ir[18:15]));
      if (trace) check("alu_op", 32'(alu_op), (c == 4) ? 32'(opc) : 32'd0);
      if (md && c == 5 + w) check("md_t5_ctrl", 32'(ctrl), 32'(M_ZLOW | M_LOIN | M_BUSY));
      start = start_mid && ir_in;
      @(negedge Clock);
      c++;
    end
    start = 1'b0; mem_ready = 1'b1;
    check("busy_drop", cyc - start_cyc, busy_lat);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'd0};
  endfunction

  initial begin
    clear = 1'b1; start = 1'b1; mem_ready = 1'b1; ir_data = '0;
    repeat (2) @(negedge Clock);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_regs", 32'({reg_out, reg_in}), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    clear = 1'b0; start = 1'b0;

    // OR R4,R3,R7
    run_instr(32'h321B_8000, 0, 1'b1, 1'b0);
    // fetch stalled for three cycles in T1
    run_instr(mk_ir(5'd3, 4'd0, 4'd1, 4'd2), 3, 1'b0, 1'b0);
    // illegal opcode, then a normal instruction
    run_instr(mk_ir(5'd31, 4'd5, 4'd6, 4'd7), 0, 1'b0, 1'b0);
    run_instr(mk_ir(5'd4, 4'd15, 4'd0, 4'd9), 0, 1'b1, 1'b0);
    // start re-pulsed during T2 must not queue another instruction
    run_instr(mk_ir(5'd5, 4'd2, 4'd3, 4'd4), 0, 1'b0, 1'b1);
    repeat (8) @(negedge Clock);
    check("no_extra_busy", 32'(busy), 32'd0);
    // MUL: two-cycle result with the option, illegal without
    run_instr(mk_ir(5'd15, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0);
    run_instr(mk_ir(5'd16, 4'd1, 4'd2, 4'd3), 1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_instr(mk_ir(5'(3 + i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15))), i % 3, (i % 3) == 0, 1'b0);
    end
    foreach (sb[i]) ;
    run_instr(mk_ir(5'd0, 4'd1, 4'd1, 4'd1), 0, 1'b0, 1'b0);
    run_instr(mk_ir(5'd11, 4'd1, 4'd1, 4'd1), 0, 1'b0, 1'b0);

    // clear asserted between edges while in T4
    ir_data = 32'h321B_8000; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (4) @(negedge Clock);
    check("pre_clear_t4", 32'(ctrl), 32'(M_ZIN | M_BUSY));
    #3 clear = 1'b1;
    #1;
    check("clear_ctrl", 32'(ctrl), 32'd0);
    check("clear_regs", 32'({reg_out, reg_in}), 32'd0);
    check("clear_alu_op", 32'(alu_op), 32'd0);
    @(negedge Clock);
    clear = 1'b0;
    run_instr(32'h321B_8000, 0, 1'b1, 1'b0);

    repeat (4) @(negedge Clock);
    check("sb_left", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
